inverter_bank: RTL and testbench
================================

INVERTER_BANK -- requirements
Module: inverter_bank

Interface
REQ-001 Parameter WIDTH, default 4: number of independent channels (1..32).
REQ-002 Parameter FILTER_CYCLES, default 4: consecutive stable synchronised samples needed to accept an input change (1..255).
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port x  input  WIDTH: asynchronous channel inputs (switches/buttons).
REQ-006 Port mask_in  input  WIDTH: new per-channel inversion mask.
REQ-007 Port mask_load  input  1: load strobe for mask_in.
REQ-008 Port invert_en  input  1: global enable; 0 = buffer mode, 1 = masked-inversion mode.
REQ-009 Port zn  output  WIDTH: registered channel outputs.
REQ-010 Port mask_out  output  WIDTH: current mask register contents.
REQ-011 Port changed  output  WIDTH: one-cycle per-channel pulse on accepted input change.

Function
REQ-012 Each x bit SHALL pass through a 2-FF synchroniser (sync1, sync2), no combinational path from x to any output.
REQ-013 Each channel SHALL hold a filtered state s[i] and a counter cnt[i] of width $clog2(FILTER_CYCLES+1).
REQ-014 If sync2[i] == s[i] at an edge, cnt[i] SHALL clear to 0.
REQ-015 If sync2[i] != s[i] and cnt[i] < FILTER_CYCLES-1, cnt[i] SHALL increment.
REQ-016 If sync2[i] != s[i] and cnt[i] == FILTER_CYCLES-1, s[i] SHALL take sync2[i] and cnt[i] SHALL clear; FILTER_CYCLES=1 accepts on first mismatch edge.
REQ-017 Any mismatch run shorter than FILTER_CYCLES edges SHALL be discarded with no change to s, zn or changed.
REQ-018 At every edge zn SHALL load s_next ^ (mask_next & {WIDTH{invert_en}}), where s_next/mask_next are values being written at that same edge.
REQ-019 Latency: x[i] changed and held before edge k -> zn[i] updated after edge k+1+FILTER_CYCLES (sync 2 edges incl. k, filter FILTER_CYCLES-1 further edges, zn registered at the accept edge).
REQ-020 changed[i] SHALL be 1 for exactly the cycle after the edge at which s[i] toggles, aligned with the zn update; otherwise 0.
REQ-021 mask_load=1 at an edge SHALL load mask_in into the mask register; zn reflects it after that same edge; no changed pulse.
REQ-022 invert_en change SHALL affect zn after the next edge; no changed pulse.
REQ-023 Simultaneous accept and mask_load on same edge: zn SHALL use both new s and new mask; changed[i] SHALL still pulse.
REQ-024 Channels SHALL be fully independent; simultaneous accepts on several channels all pulse changed in the same cycle.

Reset
REQ-025 While rst=1 at an edge: sync1, sync2, s, cnt, zn, changed SHALL clear to 0; mask SHALL load all ones.
REQ-026 Reset asserted mid-filter SHALL discard any pending change; first edge after rst deasserts computes zn per REQ-018 (all ones for x=0, invert_en=1).
REQ-027 mask_load and x SHALL be ignored on edges where rst=1.

Verification
REQ-028 Reset, x=0, invert_en=1, WIDTH=4 -> zn=4'b0000 during reset, 4'b1111 one edge after release, mask_out=4'b1111, changed=0.
REQ-029 FILTER_CYCLES=4, x[0] 0->1 held before edge k -> zn[0] falls after edge k+5, changed[0]=1 for that one cycle only.
REQ-030 x[1] pulse high for 3 synchronised cycles (FILTER_CYCLES=4) -> zn[1], changed[1] unchanged throughout.
REQ-031 mask_load=1, mask_in=4'b0101, x=4'b0000 stable -> zn=4'b0101 after the load edge; invert_en=0 -> zn=4'b0000 one edge later; no changed pulses.
REQ-032 x[2] toggled, rst asserted 2 edges into filtering -> after release zn[2] reflects only the post-reset filtered value, no stale changed pulse.
REQ-033 x[3] accept edge coincides with mask_load of mask_in=4'b0000 -> zn[3]=new s[3] with no inversion, changed[3]=1 for one cycle.

Source files
------------

// File: rtl/inverter_bank.sv
`default_nettype none
// ============================================================================
// Module   : inverter_bank
// Brief    : Debounced, synchronised input bank with per-channel masked inversion.
// Revision : 1.0 - initial release
// ============================================================================
module inverter_bank #(
  parameter int WIDTH         = 4,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] mask_in,
  input  logic             mask_load,
  input  logic             invert_en,
  output logic [WIDTH-1:0] zn,
  output logic [WIDTH-1:0] mask_out,
  output logic [WIDTH-1:0] changed
);

  localparam int            CW       = $clog2(FILTER_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] s_next;
  logic [WIDTH-1:0] mask_next;
  logic [CW-1:0]    cnt      [WIDTH];
  logic [CW-1:0]    cnt_next [WIDTH];

  assign mask_out  = mask;
  assign mask_next = mask_load ? mask_in : mask;

  // A mismatch must persist for FILTER_CYCLES consecutive edges; the last of
  // them is the accept edge, so the counter never actually reaches FILTER_CYCLES.
  always_comb begin
    s_next = s;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != s[i]) begin
        if (cnt[i] == CNT_LAST) begin
          s_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      s       <= '0;
      mask    <= '1;
      zn      <= '0;
      changed <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= x;
      sync2   <= sync1;
      s       <= s_next;
      mask    <= mask_next;
      // zn uses the values being written this edge so accept and mask load coincide cleanly
      zn      <= s_next ^ (mask_next & {WIDTH{invert_en}});
      changed <= s_next ^ s;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inverter_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_inverter_bank
// Brief    : Scoreboard bench for inverter_bank with directed per-cycle vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inverter_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] x = 4'h0;
  logic [3:0] mask_in = 4'h0;
  logic       mask_load = 1'b0;
  logic       invert_en = 1'b1;
  logic [3:0] zn;
  logic [3:0] mask_out;
  logic [3:0] changed;

  typedef struct packed {
    logic [3:0] zn;
    logic [3:0] mask;
    logic [3:0] ch;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  inverter_bank #(.WIDTH(4), .FILTER_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x),
    .mask_in   (mask_in),
    .mask_load (mask_load),
    .invert_en (invert_en),
    .zn        (zn),
    .mask_out  (mask_out),
    .changed   (changed)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per clock, pushed before the edge it describes.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cyc   = cyc + 1;
      checks = checks + 1;
      if (zn !== mon_e.zn) begin
        errors = errors + 1;
        $display("FAIL zn cycle %0d actual %b required %b", cyc, zn, mon_e.zn);
      end
      checks = checks + 1;
      if (mask_out !== mon_e.mask) begin
        errors = errors + 1;
        $display("FAIL mask_out cycle %0d actual %b required %b", cyc, mask_out, mon_e.mask);
      end
      checks = checks + 1;
      if (changed !== mon_e.ch) begin
        errors = errors + 1;
        $display("FAIL changed cycle %0d actual %b required %b", cyc, changed, mon_e.ch);
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] xv, input logic [3:0] mi,
                      input logic ml, input logic inv,
                      input logic [3:0] ezn, input logic [3:0] emask, input logic [3:0] ech);
    @(negedge clk);
    #1;
    rst       = r;
    x         = xv;
    mask_in   = mi;
    mask_load = ml;
    invert_en = inv;
    q.push_back('{zn: ezn, mask: emask, ch: ech});
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout actual running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: x and mask_load ignored, mask all ones, zn cleared
    step(1, 4'hF, 4'h0, 1, 1, 4'b0000, 4'b1111, 4'b0000);
    step(1, 4'hF, 4'h0, 1, 1, 4'b0000, 4'b1111, 4'b0000);
    // Release with x=0, invert on: all ones one edge later
    step(0, 4'h0, 4'h0, 0, 1, 4'b1111, 4'b1111, 4'b0000);
    step(0, 4'h0, 4'h0, 0, 1, 4'b1111, 4'b1111, 4'b0000);

    // Mask load visible after the load edge, then buffer mode, no pulses
    step(0, 4'h0, 4'b0101, 1, 1, 4'b0101, 4'b0101, 4'b0000);
    step(0, 4'h0, 4'b0000, 0, 0, 4'b0000, 4'b0101, 4'b0000);
    step(0, 4'h0, 4'b0000, 0, 1, 4'b0101, 4'b0101, 4'b0000);
    step(0, 4'h0, 4'b1111, 1, 1, 4'b1111, 4'b1111, 4'b0000);

    // x[0] rises before edge k: zn[0] falls after edge k+5
    for (int i = 0; i < 5; i++)
      step(0, 4'b0001, 4'h0, 0, 1, 4'b1111, 4'b1111, 4'b0000);
    step(0, 4'b0001, 4'h0, 0, 1, 4'b1110, 4'b1111, 4'b0001);
    step(0, 4'b0001, 4'h0, 0, 1, 4'b1110, 4'b1111, 4'b0000);

    // x[1] glitch of 3 synchronised cycles is discarded
    for (int i = 0; i < 3; i++)
      step(0, 4'b0011, 4'h0, 0, 1, 4'b1110, 4'b1111, 4'b0000);
    for (int i = 0; i < 6; i++)
      step(0, 4'b0001, 4'h0, 0, 1, 4'b1110, 4'b1111, 4'b0000);

    // Drop x[0] and raise x[2], reset arrives 2 edges into filtering
    for (int i = 0; i < 3; i++)
      step(0, 4'b0100, 4'h0, 0, 1, 4'b1110, 4'b1111, 4'b0000);
    step(1, 4'b0100, 4'b0000, 1, 1, 4'b0000, 4'b1111, 4'b0000);
    // Post-reset: x[2] filtered from scratch
    for (int i = 0; i < 5; i++)
      step(0, 4'b0100, 4'h0, 0, 1, 4'b1111, 4'b1111, 4'b0000);
    step(0, 4'b0100, 4'h0, 0, 1, 4'b1011, 4'b1111, 4'b0100);
    step(0, 4'b0100, 4'h0, 0, 1, 4'b1011, 4'b1111, 4'b0000);

    // Simultaneous accepts on channels 0 and 3; accept edge shares a mask load of zero
    for (int i = 0; i < 5; i++)
      step(0, 4'b1101, 4'h0, 0, 1, 4'b1011, 4'b1111, 4'b0000);
    step(0, 4'b1101, 4'b0000, 1, 1, 4'b1101, 4'b0000, 4'b1001);
    step(0, 4'b1101, 4'b0000, 0, 1, 4'b1101, 4'b0000, 4'b0000);
    step(0, 4'b1101, 4'b0000, 0, 0, 4'b1101, 4'b0000, 4'b0000);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 4; i++) begin
      if (q.size() > 0) @(negedge clk);
    end
    #1;
    checks = checks + 1;
    if (q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain actual %0d pending required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
